// File: rtl/rnn_h_monitor_if.sv
// Snoop bus from the RNN core plus the result stream handshake.
// The slave side is the monitor; the master side drives the bus and consumes results.
interface rnn_h_monitor_if;
  logic        mce;
  logic [2:0]  msel;
  logic [16:0] maddr;
  logic [19:0] mdata_w;
  logic        o_valid;
  logic        o_ready;
  logic [10:0] o_t;
  logic [5:0]  o_idx;
  logic [19:0] o_max;
  logic [25:0] o_sum;

  modport slave (
    input  mce, msel, maddr, mdata_w, o_ready,
    output o_valid, o_t, o_idx, o_max, o_sum
  );

  modport master (
    output mce, msel, maddr, mdata_w, o_ready,
    input  o_valid, o_t, o_idx, o_max, o_sum
  );
endinterface

// File: rtl/rnn_h_monitor.sv
// Watches hidden-state writes and reduces each 64-entry timestep to {t, argmax, max, sum}.
// Completed results are queued in a small FIFO for the consumer.
module rnn_h_monitor #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  rnn_h_monitor_if.slave   bus,
  output logic             seq_err,
  output logic             ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [10:0] t;
    logic [5:0]  idx;
    logic [19:0] mx;
    logic [25:0] sum;
  } res_t;

  logic        sample;
  logic [5:0]  h;
  logic [5:0]  exp_h;
  logic        pend;
  res_t        acc, nxt, res;

  assign sample = bus.mce && (bus.msel == 3'b101);
  assign h      = bus.maddr[5:0];

  // h=0 always starts a fresh timestep, in or out of order
  always_comb begin
    nxt = acc;
    if (h == 6'd0) begin
      nxt.t   = bus.maddr[16:6];
      nxt.idx = 6'd0;
      nxt.mx  = bus.mdata_w;
      nxt.sum = {{6{bus.mdata_w[19]}}, bus.mdata_w};
    end else begin
      nxt.sum = acc.sum + {{6{bus.mdata_w[19]}}, bus.mdata_w};
      if ($signed(bus.mdata_w) > $signed(acc.mx)) begin
        nxt.mx  = bus.mdata_w;
        nxt.idx = h;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_h   <= 6'd0;
      acc     <= '0;
      res     <= '0;
      pend    <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      pend <= 1'b0;
      if (sample) begin
        if (h == exp_h || h == 6'd0) begin
          acc   <= nxt;
          exp_h <= h + 6'd1;
          if (h != exp_h) seq_err <= 1'b1;
          if (h == 6'd63) begin
            res  <= nxt;
            pend <= 1'b1;
          end
        end else begin
          seq_err <= 1'b1;
          exp_h   <= 6'd0;
        end
      end
    end
  end

  // Result FIFO: extra pointer bit distinguishes full from empty
  res_t        mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic        empty, full, pop, push;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = !empty && bus.o_ready;
  assign push  = pend && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      ovf <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp[AW-1:0]] <= res;
        wp              <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      if (pend && full && !pop) ovf <= 1'b1;
    end
  end

  assign bus.o_valid = !empty;
  assign bus.o_t     = mem[rp[AW-1:0]].t;
  assign bus.o_idx   = mem[rp[AW-1:0]].idx;
  assign bus.o_max   = mem[rp[AW-1:0]].mx;
  assign bus.o_sum   = mem[rp[AW-1:0]].sum;
endmodule

// File: tb/tb_rnn_h_monitor.sv
// Directed bench for rnn_h_monitor: ramp/negative timesteps, overflow, sequence errors,
// mid-timestep reset and interleaved bus traffic with random back-pressure.
module tb_rnn_h_monitor;
  logic clk = 1'b0;
  logic reset;
  logic seq_err, ovf;
  int   n_chk = 0;
  int   n_err = 0;

  rnn_h_monitor_if ifc ();

  rnn_h_monitor #(.FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (ifc.slave),
    .seq_err (seq_err),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  logic rdy_dir = 1'b0;
  logic rdy_rnd = 1'b0;
  logic rnd_en  = 1'b0;
  logic [62:0] log_q [$];

  assign ifc.o_ready = rnd_en ? rdy_rnd : rdy_dir;

  // Random back-pressure; logs the entry that the next edge pops
  always @(negedge clk) begin
    logic r;
    r = 1'($urandom_range(0, 1));
    rdy_rnd = r;
    if (rnd_en && r && ifc.o_valid)
      log_q.push_back({ifc.o_t, ifc.o_idx, ifc.o_max, ifc.o_sum});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ifc.mce = 1'b0; ifc.msel = 3'b101; ifc.maddr = '0; ifc.mdata_w = '0;
  endtask

  task automatic junk();
    if ($urandom_range(0, 1) == 0) begin
      ifc.mce = 1'b1; ifc.msel = 3'b010;
    end else begin
      ifc.mce = 1'b0; ifc.msel = 3'b101;
    end
    ifc.maddr   = 17'($urandom);
    ifc.maddr[5:0] = 6'd0;
    ifc.mdata_w = 20'($urandom);
    @(negedge clk);
  endtask

  // Sends h=0..stop-1 of timestep t; skip<0 means no skipped index
  task automatic send_ts(input logic [10:0] t, input bit neg, input bit ilv,
                         input int skip, input int stop);
    for (int hh = 0; hh < stop; hh++) begin
      if (hh != skip) begin
        if (ilv) begin
          int nj;
          nj = $urandom_range(0, 2);
          for (int j = 0; j < nj; j++) junk();
        end
        ifc.mce     = 1'b1;
        ifc.msel    = 3'b101;
        ifc.maddr   = {t, 6'(hh)};
        ifc.mdata_w = neg ? 20'hF0000 : 20'(hh * 256);
        @(negedge clk);
      end
    end
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pop_one();
    rdy_dir = 1'b1;
    @(negedge clk);
    rdy_dir = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [10:0] t, input bit neg);
    chk({tag, "_t"},   64'(ifc.o_t),   64'(t));
    chk({tag, "_idx"}, 64'(ifc.o_idx), neg ? 64'd0 : 64'd63);
    chk({tag, "_max"}, 64'(ifc.o_max), neg ? 64'h0F0000 : 64'h003F00);
    chk({tag, "_sum"}, 64'(ifc.o_sum), neg ? 64'h3C00000 : 64'h007E000);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_valid", 64'(ifc.o_valid), 64'd0);
    chk("rst_seq",   64'(seq_err),     64'd0);
    chk("rst_ovf",   64'(ovf),         64'd0);
    chk("rst_t",     64'(ifc.o_t),     64'd0);
    chk("rst_sum",   64'(ifc.o_sum),   64'd0);

    // Ramp: o_valid low one edge after h=63, high after the second
    send_ts(11'd0, 1'b0, 1'b0, -1, 64);
    chk("ramp_lat1", 64'(ifc.o_valid), 64'd0);
    @(negedge clk);
    chk("ramp_lat2", 64'(ifc.o_valid), 64'd1);
    chk_head("ramp", 11'd0, 1'b0);
    pop_one();
    chk("ramp_empty", 64'(ifc.o_valid), 64'd0);

    // All -1.0: ties keep index 0
    send_ts(11'd1, 1'b1, 1'b0, -1, 64);
    @(negedge clk);
    chk_head("neg", 11'd1, 1'b1);
    pop_one();

    // Five timesteps with no consumer: fifth dropped
    for (int t = 0; t < 5; t++) send_ts(11'(t), 1'b0, 1'b0, -1, 64);
    repeat (2) @(negedge clk);
    chk("ovf_set",   64'(ovf),         64'd1);
    chk("ovf_valid", 64'(ifc.o_valid), 64'd1);
    for (int t = 0; t < 4; t++) begin
      chk("drain_t", 64'(ifc.o_t), 64'(t));
      pop_one();
    end
    chk("drain_empty", 64'(ifc.o_valid), 64'd0);
    chk("ovf_seq",     64'(seq_err),     64'd0);
    do_reset();
    chk("ovf_clr", 64'(ovf), 64'd0);

    // Skipped h=10: error, no entry; next clean timestep is correct
    send_ts(11'd2, 1'b0, 1'b0, 10, 64);
    repeat (3) @(negedge clk);
    chk("skip_seq",   64'(seq_err),     64'd1);
    chk("skip_valid", 64'(ifc.o_valid), 64'd0);
    send_ts(11'd3, 1'b0, 1'b0, -1, 64);
    @(negedge clk);
    chk("clean_valid", 64'(ifc.o_valid), 64'd1);
    chk_head("clean", 11'd3, 1'b0);
    pop_one();

    // Reset lands on the h=30 sample of t=6
    do_reset();
    send_ts(11'd6, 1'b0, 1'b0, -1, 30);
    ifc.mce = 1'b1; ifc.msel = 3'b101; ifc.maddr = {11'd6, 6'd30}; ifc.mdata_w = 20'h01E00;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle();
    send_ts(11'd7, 1'b0, 1'b0, -1, 64);
    @(negedge clk);
    chk("rst30_valid", 64'(ifc.o_valid), 64'd1);
    chk_head("rst30", 11'd7, 1'b0);
    chk("rst30_seq", 64'(seq_err), 64'd0);
    pop_one();
    chk("rst30_one", 64'(ifc.o_valid), 64'd0);

    // Interleaved traffic and random o_ready
    rnd_en = 1'b1;
    send_ts(11'd5, 1'b0, 1'b1, -1, 64);
    send_ts(11'd6, 1'b1, 1'b1, -1, 64);
    for (int c = 0; c < 300 && log_q.size() < 2; c++) @(negedge clk);
    rnd_en = 1'b0;
    chk("ilv_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() >= 2) begin
      chk("ilv_e0", 64'(log_q[0]), 64'({11'd5, 6'd63, 20'h03F00, 26'h007E000}));
      chk("ilv_e1", 64'(log_q[1]), 64'({11'd6, 6'd0,  20'hF0000, 26'h3C00000}));
    end
    @(negedge clk);
    chk("ilv_seq", 64'(seq_err), 64'd0);
    chk("ilv_ovf", 64'(ovf),     64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rnn_h_monitor.md
RNN_H_MONITOR -- requirements
Module: rnn_h_monitor

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-002 SHALL provide port clk  input  1  sole clock, rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port mce  input  1  memory chip enable, snooped from the RNN core.
REQ-005 SHALL provide port msel  input  3  memory select, snooped; 3'b101 = hidden-state result write.
REQ-006 SHALL provide port maddr  input  17  memory address, snooped; [16:6] = timestep t, [5:0] = hidden index h.
REQ-007 SHALL provide port mdata_w  input  20  written hidden value, signed Q4.16, saturated to 0xF0000..0x10000.
REQ-008 SHALL provide port o_valid  output  1  result FIFO non-empty.
REQ-009 SHALL provide port o_ready  input  1  consumer accepts the head entry.
REQ-010 SHALL provide port o_t  output  11  timestep of the head entry.
REQ-011 SHALL provide port o_idx  output  6  argmax hidden index of the head entry.
REQ-012 SHALL provide port o_max  output  20  max signed value of the head entry.
REQ-013 SHALL provide port o_sum  output  26  signed sum of all 64 values of the head entry.
REQ-014 SHALL provide port seq_err  output  1  sticky: out-of-order h index seen.
REQ-015 SHALL provide port ovf  output  1  sticky: completed result dropped because the FIFO was full.

Function
REQ-016 SHALL treat a cycle as a sample when mce=1 and msel=3'b101 at the rising edge; all other cycles are ignored.
REQ-017 SHALL keep expected index exp_h (6 bit); a sample with h==exp_h is accepted and exp_h increments, wrapping 63->0.
REQ-018 SHALL, on an accepted h=0, load max=mdata_w, idx=0, sum=sign-extended mdata_w, and latch t=maddr[16:6].
REQ-019 SHALL, on an accepted h>0, add sign-extended mdata_w to sum (26-bit, no overflow possible), and replace max/idx only when mdata_w > max (signed strict, so ties keep the lower index).
REQ-020 SHALL, on a sample with h!=exp_h, set seq_err, discard the partial accumulation, and restart as in REQ-018 if h==0 (exp_h=1), else set exp_h=0.
REQ-021 SHALL ignore a t mismatch within a timestep; t is taken from the h=0 sample only.
REQ-022 SHALL register the completed {t,idx,max,sum} at the edge accepting h=63 and push it into the FIFO at the following edge; o_valid rises 2 edges after the h=63 sample when the FIFO was empty.
REQ-023 SHALL pop the head at an edge where o_valid=1 and o_ready=1; o_t/o_idx/o_max/o_sum hold stable while o_valid=1 and o_ready=0.
REQ-024 SHALL, on a push with the FIFO full and no simultaneous pop, drop the new result and set ovf; with a simultaneous pop the push SHALL succeed.
REQ-025 SHALL accept a new h=0 sample on the cycle immediately after h=63 (back-to-back timesteps, no bubble).
REQ-026 SHALL drive output data fields from FIFO storage directly; they are don't-care while o_valid=0.

Reset
REQ-027 SHALL, when reset=1 at an edge, clear the FIFO (o_valid=0), exp_h=0, accumulators, pending push, seq_err=0 and ovf=0; o_t/o_idx/o_max/o_sum read 0.
REQ-028 SHALL give reset priority over simultaneous samples, pushes and pops; a timestep in progress is abandoned.

Verification
REQ-029 Bench SHALL write t=0, h=0..63 with value 0x00100*h -> one entry, o_idx=63, o_max=0x03F00, o_sum=0x7E000, o_valid 2 edges after h=63.
REQ-030 Bench SHALL write all 64 values = 0xF0000 (-1.0) -> o_idx=0, o_max=0xF0000, o_sum=-64.0 (26'h3C00000).
REQ-031 Bench SHALL hold o_ready=0 across 5 complete timesteps (t=0..4) -> entries for t=0..3 kept, t=4 dropped, ovf=1; draining returns t=0,1,2,3 in order.
REQ-032 Bench SHALL skip h=10 within a timestep -> seq_err=1, no entry pushed; next clean timestep yields a correct entry.
REQ-033 Bench SHALL assert reset at h=30 of a timestep, then send a full timestep t=7 -> only one entry, o_t=7, seq_err=0.
REQ-034 Bench SHALL interleave msel=3'b010 and mce=0 cycles between samples and toggle o_ready randomly -> results identical to the uninterleaved run.
